// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, format tags,
// the canonical NOP and the registered field bundle.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    // Everything the stage registers apart from valid and pc.
    typedef struct packed {
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        illegal;
    } fields_t;

    // Bubble contents: raw insn reads as NOP, every decoded field is zero.
    localparam fields_t FIELDS_BUBBLE = '{
        insn:    NOP_INSN,
        opcode:  7'd0,
        rd:      5'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        funct3:  3'd0,
        funct7:  7'd0,
        shamt:   5'd0,
        imm:     32'd0,
        illegal: 1'b0
    };

endpackage

// File: rtl/imm_gen.sv
// Combinational format classification and immediate generation for RV32I.
// FENCE is tagged FMT_X (no immediate) even though it is a legal opcode;
// the legality decision is made in decode.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic [31:0] imm_o,
    output fmt_e        fmt_o
);

    // Classify the instruction format from the opcode.
    always_comb begin
        fmt_o = FMT_X;
        case (insn_i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: fmt_o = FMT_I;
            OPC_STORE:                                 fmt_o = FMT_S;
            OPC_BRANCH:                                fmt_o = FMT_B;
            OPC_LUI, OPC_AUIPC:                        fmt_o = FMT_U;
            OPC_JAL:                                   fmt_o = FMT_J;
            OPC_OP:                                    fmt_o = FMT_R;
            default:                                   fmt_o = FMT_X;
        endcase
    end

    // Assemble the sign-extended immediate for the selected format.
    always_comb begin
        imm_o = 32'd0;
        case (fmt_o)
            FMT_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
            FMT_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            FMT_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                            insn_i[30:25], insn_i[11:8], 1'b0};
            FMT_U: imm_o = {insn_i[31:12], 12'd0};
            FMT_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                            insn_i[20], insn_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: one register bank behind combinational field
// extraction. Update priority is rst > flush > stall > load.
module decode
    import rv32i_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [31:0]       imm_o,
    output logic              illegal_o
);

    logic [31:0]       imm_dec;
    fmt_e              fmt_dec;
    logic              illegal_dec;
    fields_t           load_fields;

    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    fields_t           fields_q, fields_d;

    imm_gen u_imm_gen (
        .insn_i (insn_i),
        .imm_o  (imm_dec),
        .fmt_o  (fmt_dec)
    );

    // Unknown opcodes, and R-type funct7 values outside ADD/SUB/SRL/SRA rules.
    always_comb begin
        illegal_dec = 1'b0;
        if (fmt_dec == FMT_X && insn_i[6:0] != OPC_FENCE) begin
            illegal_dec = 1'b1;
        end
        if (fmt_dec == FMT_R) begin
            if (!(insn_i[31:25] == 7'b0000000 ||
                  (insn_i[31:25] == 7'b0100000 &&
                   (insn_i[14:12] == 3'b000 || insn_i[14:12] == 3'b101)))) begin
                illegal_dec = 1'b1;
            end
        end
    end

    // Decoded contents for a load; an invalid slot loads the bubble.
    always_comb begin
        load_fields = FIELDS_BUBBLE;
        if (valid_i) begin
            load_fields.insn    = insn_i;
            load_fields.opcode  = insn_i[6:0];
            load_fields.rd      = insn_i[11:7];
            load_fields.rs1     = insn_i[19:15];
            load_fields.rs2     = insn_i[24:20];
            load_fields.funct3  = insn_i[14:12];
            load_fields.funct7  = insn_i[31:25];
            load_fields.shamt   = insn_i[24:20];
            load_fields.imm     = imm_dec;
            load_fields.illegal = illegal_dec;
        end
    end

    // Next-state selection: flush beats stall, stall beats load.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        fields_d = fields_q;
        if (flush_i) begin
            valid_d  = 1'b0;
            pc_d     = BASEADDR;
            fields_d = FIELDS_BUBBLE;
        end else if (!stall_i) begin
            valid_d  = valid_i;
            pc_d     = pc_i;
            fields_d = load_fields;
        end
    end

    // Output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= BASEADDR;
            fields_q <= FIELDS_BUBBLE;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            fields_q <= fields_d;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign insn_o    = fields_q.insn;
    assign opcode_o  = fields_q.opcode;
    assign rd_o      = fields_q.rd;
    assign rs1_o     = fields_q.rs1;
    assign rs2_o     = fields_q.rs2;
    assign funct3_o  = fields_q.funct3;
    assign funct7_o  = fields_q.funct7;
    assign shamt_o   = fields_q.shamt;
    assign imm_o     = fields_q.imm;
    assign illegal_o = fields_q.illegal;

endmodule
